// File: rtl/data_mem_ctrl_pkg.sv
// Shared types and default latencies for the data memory request sequencer.
package data_mem_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_WAIT,
        ST_RESP
    } ctrl_state_t;

    typedef enum logic [1:0] {
        LVL_L1,
        LVL_L2,
        LVL_L3,
        LVL_MEM
    } mem_level_t;

    localparam int DEF_L2_LAT  = 4;
    localparam int DEF_L3_LAT  = 10;
    localparam int DEF_MEM_LAT = 20;
    localparam int DEF_CNT_W   = 5;

endpackage

// File: rtl/mem_lat_cnt.sv
// Loadable down-counter that times out the latency of the serving memory level.
// Load has priority over decrement; zero_o is combinational from the count.
module mem_lat_cnt #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/data_mem_ctrl.sv
// One-at-a-time load/store sequencer: latches the LSU request, waits out the serving level's latency,
// returns a single response pulse and stalls the pipeline meanwhile; keeps per-level read-hit counters.
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int L2_LAT  = DEF_L2_LAT,
    parameter int L3_LAT  = DEF_L3_LAT,
    parameter int MEM_LAT = DEF_MEM_LAT,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_wr_en_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wr_data_i,
    input  logic [3:0]  req_byte_en_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rd_data_o,
    output logic        stall_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wr_data_o,
    output logic [3:0]  mem_byte_en_o,
    output logic        mem_wr_en_o,
    input  logic [31:0] mem_rd_data_i,
    input  logic        l1_hit_i,
    input  logic        l2_hit_i,
    input  logic        l3_hit_i
);

    // The LOOKUP cycle itself counts toward nothing; WAIT runs from LAT-1 down to 0 inclusive.
    localparam logic [CNT_W-1:0] L2_LOAD  = CNT_W'(L2_LAT - 1);
    localparam logic [CNT_W-1:0] L3_LOAD  = CNT_W'(L3_LAT - 1);
    localparam logic [CNT_W-1:0] MEM_LOAD = CNT_W'(MEM_LAT - 1);

    ctrl_state_t state_q, state_d;
    mem_level_t  level_q, level_d;

    logic [31:0] addr_q;
    logic [31:0] wr_data_q;
    logic [3:0]  byte_en_q;
    logic        wr_en_q;
    logic [31:0] rd_data_q;

    logic [31:0] rd_hit_cnt_l1;
    logic [31:0] rd_hit_cnt_l2;
    logic [31:0] rd_hit_cnt_l3;
    logic [31:0] rd_hit_cnt_mem;

    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_dec;
    logic             cnt_zero;
    logic             capture;
    logic [31:0]      capture_val;
    logic             accept;

    assign accept = (state_q == ST_IDLE) && req_valid_i;

    mem_lat_cnt #(
        .CNT_W (CNT_W)
    ) u_lat_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            level_q <= LVL_L1;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        level_d      = level_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        capture      = 1'b0;
        capture_val  = '0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) state_d = ST_LOOKUP;
            end
            ST_LOOKUP: begin
                if (wr_en_q) begin
                    capture = 1'b1;
                    state_d = ST_RESP;
                end else if (l1_hit_i) begin
                    capture     = 1'b1;
                    capture_val = mem_rd_data_i;
                    level_d     = LVL_L1;
                    state_d     = ST_RESP;
                end else begin
                    cnt_load = 1'b1;
                    state_d  = ST_WAIT;
                    if (l2_hit_i) begin
                        level_d      = LVL_L2;
                        cnt_load_val = L2_LOAD;
                    end else if (l3_hit_i) begin
                        level_d      = LVL_L3;
                        cnt_load_val = L3_LOAD;
                    end else begin
                        level_d      = LVL_MEM;
                        cnt_load_val = MEM_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_zero) begin
                    capture     = 1'b1;
                    capture_val = mem_rd_data_i;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign cnt_dec = (state_q == ST_WAIT) && !cnt_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '0;
            wr_data_q <= '0;
            byte_en_q <= '0;
            wr_en_q   <= 1'b0;
        end else if (accept) begin
            addr_q    <= req_addr_i;
            wr_data_q <= req_wr_data_i;
            byte_en_q <= req_byte_en_i;
            wr_en_q   <= req_wr_en_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if (capture) begin
            rd_data_q <= capture_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_hit_cnt_l1  <= '0;
            rd_hit_cnt_l2  <= '0;
            rd_hit_cnt_l3  <= '0;
            rd_hit_cnt_mem <= '0;
        end else if (state_q == ST_RESP && !wr_en_q) begin
            case (level_q)
                LVL_L1:  rd_hit_cnt_l1  <= rd_hit_cnt_l1 + 32'd1;
                LVL_L2:  rd_hit_cnt_l2  <= rd_hit_cnt_l2 + 32'd1;
                LVL_L3:  rd_hit_cnt_l3  <= rd_hit_cnt_l3 + 32'd1;
                default: rd_hit_cnt_mem <= rd_hit_cnt_mem + 32'd1;
            endcase
        end
    end

    assign req_ready_o    = (state_q == ST_IDLE);
    assign stall_o        = (state_q == ST_LOOKUP) || (state_q == ST_WAIT);
    assign resp_valid_o   = (state_q == ST_RESP);
    assign resp_rd_data_o = rd_data_q;
    assign mem_wr_en_o    = (state_q == ST_LOOKUP) && wr_en_q;
    assign mem_addr_o     = addr_q;
    assign mem_wr_data_o  = wr_data_q;
    assign mem_byte_en_o  = byte_en_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Randomized and directed bench for data_mem_ctrl against a transaction-level latency/counter model.
module tb_data_mem_ctrl;

    localparam int L2_LAT  = 4;
    localparam int L3_LAT  = 10;
    localparam int MEM_LAT = 20;
    localparam int CNT_W   = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wr_en = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wr_data = '0;
    logic [3:0]  req_byte_en = '0;
    logic        resp_valid;
    logic [31:0] resp_rd_data;
    logic        stall;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic [3:0]  mem_byte_en;
    logic        mem_wr_en;
    logic [31:0] mem_rd_data = '0;
    logic        l1_hit = 1'b0;
    logic        l2_hit = 1'b0;
    logic        l3_hit = 1'b0;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_cnt [4];

    always #5 clk = ~clk;

    data_mem_ctrl #(
        .L2_LAT  (L2_LAT),
        .L3_LAT  (L3_LAT),
        .MEM_LAT (MEM_LAT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_wr_en_i    (req_wr_en),
        .req_addr_i     (req_addr),
        .req_wr_data_i  (req_wr_data),
        .req_byte_en_i  (req_byte_en),
        .resp_valid_o   (resp_valid),
        .resp_rd_data_o (resp_rd_data),
        .stall_o        (stall),
        .mem_addr_o     (mem_addr),
        .mem_wr_data_o  (mem_wr_data),
        .mem_byte_en_o  (mem_byte_en),
        .mem_wr_en_o    (mem_wr_en),
        .mem_rd_data_i  (mem_rd_data),
        .l1_hit_i       (l1_hit),
        .l2_hit_i       (l2_hit),
        .l3_hit_i       (l3_hit)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] dut_cnt(input int lvl);
        case (lvl)
            0:       return dut.rd_hit_cnt_l1;
            1:       return dut.rd_hit_cnt_l2;
            2:       return dut.rd_hit_cnt_l3;
            default: return dut.rd_hit_cnt_mem;
        endcase
    endfunction

    task automatic check_counters(input string tag);
        for (int l = 0; l < 4; l++)
            check($sformatf("%s_cnt%0d", tag, l), dut_cnt(l), exp_cnt[l]);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        check({tag, "_resp_vld"}, {31'd0, resp_valid}, 32'd0);
        check({tag, "_stall"}, {31'd0, stall}, 32'd0);
        check({tag, "_wr_en"}, {31'd0, mem_wr_en}, 32'd0);
        check({tag, "_addr"}, mem_addr, 32'd0);
        check({tag, "_wdata"}, mem_wr_data, 32'd0);
        check({tag, "_be"}, {28'd0, mem_byte_en}, 32'd0);
        check({tag, "_rdata"}, resp_rd_data, 32'd0);
    endtask

    // Called at a point before the negedge of an IDLE cycle; returns #1 after a rising edge in IDLE.
    task automatic run_txn(input string tag, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be,
                           input logic [2:0] hits, input logic [31:0] rdata);
        int          lvl;
        int          resp_c;
        logic [31:0] exp_data;
        lvl = hits[0] ? 0 : hits[1] ? 1 : hits[2] ? 2 : 3;
        if (wr || lvl == 0)   resp_c = 2;
        else if (lvl == 1)    resp_c = 2 + L2_LAT;
        else if (lvl == 2)    resp_c = 2 + L3_LAT;
        else                  resp_c = 2 + MEM_LAT;
        exp_data = wr ? 32'd0 : rdata;

        req_valid   = 1'b1;
        req_wr_en   = wr;
        req_addr    = addr;
        req_wr_data = wdata;
        req_byte_en = be;
        {l3_hit, l2_hit, l1_hit} = 3'($urandom);
        mem_rd_data = $urandom;
        @(negedge clk);
        check({tag, "_ready_idle"}, {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        // Scramble the request bus to prove the controller latched it.
        req_valid   = 1'b0;
        req_wr_en   = 1'($urandom);
        req_addr    = $urandom;
        req_wr_data = $urandom;
        req_byte_en = 4'($urandom);
        for (int c = 1; c <= resp_c; c++) begin
            if (c == 1) {l3_hit, l2_hit, l1_hit} = hits;
            else        {l3_hit, l2_hit, l1_hit} = 3'($urandom);
            mem_rd_data = (c == resp_c - 1) ? rdata : $urandom;
            @(negedge clk);
            check($sformatf("%s_stall_c%0d", tag, c), {31'd0, stall}, {31'd0, c < resp_c});
            check($sformatf("%s_resp_vld_c%0d", tag, c), {31'd0, resp_valid}, {31'd0, c == resp_c});
            check($sformatf("%s_ready_c%0d", tag, c), {31'd0, req_ready}, 32'd0);
            check($sformatf("%s_wr_en_c%0d", tag, c), {31'd0, mem_wr_en}, {31'd0, wr && c == 1});
            check($sformatf("%s_addr_c%0d", tag, c), mem_addr, addr);
            if (c == 1 || c == resp_c) begin
                check($sformatf("%s_wdata_c%0d", tag, c), mem_wr_data, wdata);
                check($sformatf("%s_be_c%0d", tag, c), {28'd0, mem_byte_en}, {28'd0, be});
            end
            if (c == resp_c)
                check({tag, "_rdata"}, resp_rd_data, exp_data);
            @(posedge clk);
            #1;
        end
        if (!wr) exp_cnt[lvl] = exp_cnt[lvl] + 32'd1;
        @(negedge clk);
        check({tag, "_ready_after"}, {31'd0, req_ready}, 32'd1);
        check({tag, "_resp_vld_after"}, {31'd0, resp_valid}, 32'd0);
        check({tag, "_rdata_hold"}, resp_rd_data, exp_data);
        check_counters(tag);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic seen_resp;
        for (int l = 0; l < 4; l++) exp_cnt[l] = '0;

        #1;
        check_reset_outputs("por");
        check_counters("por");
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        run_txn("l1_load", 1'b0, 32'h0000_0100, 32'h0, 4'hF, 3'b001, 32'hDEAD_BEEF);
        run_txn("l3_load", 1'b0, 32'h0000_0240, 32'h0, 4'hF, 3'b100, 32'h0BAD_F00D);
        run_txn("store", 1'b1, 32'h0000_0300, 32'h1234_5678, 4'b0011, 3'b000, 32'hFFFF_FFFF);
        run_txn("l1_l2", 1'b0, 32'h0000_0404, 32'h0, 4'hF, 3'b011, 32'h5555_AAAA);
        run_txn("l2_load", 1'b0, 32'h0000_0508, 32'h0, 4'hF, 3'b010, 32'h1357_9BDF);
        run_txn("mem_load", 1'b0, 32'h0000_060C, 32'h0, 4'hF, 3'b000, 32'h2468_ACE0);
        run_txn("store_be0", 1'b1, 32'h0000_0710, 32'hCAFE_0001, 4'b0000, 3'b001, 32'h7777_7777);

        // Request held valid back-to-back: accepts at edges 0, 3, 6.
        req_valid   = 1'b1;
        req_wr_en   = 1'b0;
        req_addr    = 32'h0000_0800;
        req_byte_en = 4'hF;
        {l3_hit, l2_hit, l1_hit} = 3'b001;
        mem_rd_data = 32'hA5A5_3C3C;
        @(negedge clk);
        check("b2b_ready_c0", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            check($sformatf("b2b_resp_vld_c%0d", c), {31'd0, resp_valid}, {31'd0, (c % 3) == 2});
            check($sformatf("b2b_ready_c%0d", c), {31'd0, req_ready}, {31'd0, (c % 3) == 0});
            if ((c % 3) == 2) check($sformatf("b2b_rdata_c%0d", c), resp_rd_data, 32'hA5A5_3C3C);
            if (c == 9) req_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        exp_cnt[0] = exp_cnt[0] + 32'd3;
        check_counters("b2b");

        for (int t = 0; t < 40; t++) begin
            logic wr;
            wr = ($urandom_range(0, 3) == 0);
            run_txn($sformatf("rnd%0d", t), wr, $urandom, $urandom, 4'($urandom),
                    3'($urandom), $urandom);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        // Reset in the middle of a main-memory wait drops the request.
        req_valid   = 1'b1;
        req_wr_en   = 1'b0;
        req_addr    = 32'h0000_0A00;
        req_byte_en = 4'hF;
        {l3_hit, l2_hit, l1_hit} = 3'b000;
        mem_rd_data = 32'h1111_2222;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        check("mid_wait_stall", {31'd0, stall}, 32'd1);
        rst_n = 1'b0;
        #1;
        for (int l = 0; l < 4; l++) exp_cnt[l] = '0;
        check_reset_outputs("arst");
        check_counters("arst");
        seen_resp = 1'b0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (resp_valid) seen_resp = 1'b1;
        end
        check("arst_no_resp", {31'd0, seen_resp}, 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        run_txn("post_rst", 1'b0, 32'h0000_0B00, 32'h0, 4'hF, 3'b010, 32'h9999_8888);
        run_txn("post_rst_mem", 1'b0, 32'h0000_0B04, 32'h0, 4'hF, 3'b000, 32'h0123_4567);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
